// File: rtl/exec_hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_hazard_if
// Brief    : Decode-side hazard/forwarding bundle between decode and the
//            execute-stage hazard controller.
// Revision : 1.0
// ============================================================================
interface exec_hazard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1_sel;
    logic [4:0]       id_rs2_sel;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd_sel;
    logic             id_write_enable;
    logic             id_is_load;
    logic             id_is_mc;
    logic             branch_flush;
    logic             stall;
    logic             ex_bubble;
    logic             ex_hold;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
               id_rd_sel, id_write_enable, id_is_load, id_is_mc, branch_flush,
        input  stall, ex_bubble, ex_hold, fwd_rs1_sel, fwd_rs2_sel, mc_busy,
               stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
               id_rd_sel, id_write_enable, id_is_load, id_is_mc, branch_flush,
        output stall, ex_bubble, ex_hold, fwd_rs1_sel, fwd_rs2_sel, mc_busy,
               stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/exec_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exec_hazard_ctrl
// Brief    : EX/MEM/WB destination scoreboard, operand-forwarding selects and
//            stall/bubble/hold sequencing for load-use and multi-cycle ops.
// Revision : 1.0
// ============================================================================
module exec_hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  wire          clk,
    input  wire          rst_n,
    exec_hazard_if.slave hz
);

    typedef struct packed {
        logic       v;
        logic       we;
        logic       ld;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    localparam logic [3:0]       MC_LOAD = 4'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam sb_entry_t        SB_NONE = '0;

    sb_entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t           state_q, state_d;
    logic [3:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic       mc_hold;
    logic       ex_prod, mem_prod;
    logic       rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic       load_use;
    logic       stall_c, bubble_c, issue;
    logic [1:0] fwd1_c, fwd2_c;
    logic       unused_sb;

    // The WB entry is tracked for completeness; the regfile writes through.
    assign unused_sb = ^{wb_q, mem_q.ld};

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic ex_ld,
                                           input logic hold, input logic hit_mem);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit_ex && !ex_ld && !hold) begin
            sel = 2'b01;
        end else if (hit_mem) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        mc_hold  = (state_q == ST_MC_BUSY) && (mc_cnt_q != 4'd0);
        ex_prod  = ex_q.v && ex_q.we && (ex_q.rd != 5'd0);
        mem_prod = mem_q.v && mem_q.we && (mem_q.rd != 5'd0);
        rs1_ex   = hz.id_rs1_used && ex_prod  && (hz.id_rs1_sel == ex_q.rd);
        rs2_ex   = hz.id_rs2_used && ex_prod  && (hz.id_rs2_sel == ex_q.rd);
        rs1_mem  = hz.id_rs1_used && mem_prod && (hz.id_rs1_sel == mem_q.rd);
        rs2_mem  = hz.id_rs2_used && mem_prod && (hz.id_rs2_sel == mem_q.rd);
        // No decode instruction means nothing to hold back.
        load_use = hz.id_valid && ex_q.ld && (rs1_ex || rs2_ex);
        fwd1_c   = fwd_sel(rs1_ex, ex_q.ld, mc_hold, rs1_mem);
        fwd2_c   = fwd_sel(rs2_ex, ex_q.ld, mc_hold, rs2_mem);

        stall_c  = 1'b0;
        bubble_c = 1'b0;
        if (mc_hold) begin
            stall_c = 1'b1;
        end else if (hz.branch_flush) begin
            bubble_c = 1'b1;
        end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end
        issue = hz.id_valid && !stall_c && !hz.branch_flush;
    end

    always_comb begin
        ex_d           = ex_q;
        mem_d          = ex_q;
        wb_d           = mem_q;
        state_d        = state_q;
        mc_cnt_d       = mc_cnt_q;
        stall_cycles_d = stall_cycles_q;

        if (mc_hold) begin
            mem_d    = SB_NONE;
            mc_cnt_d = mc_cnt_q - 4'd1;
        end else begin
            ex_d = issue ? '{v: 1'b1, we: hz.id_write_enable, ld: hz.id_is_load,
                             rd: hz.id_rd_sel} : SB_NONE;
            // Covers both IDLE entry and back-to-back re-entry at release.
            if (issue && hz.id_is_mc) begin
                state_d  = ST_MC_BUSY;
                mc_cnt_d = MC_LOAD;
            end else begin
                state_d  = ST_IDLE;
                mc_cnt_d = 4'd0;
            end
        end

        if (stall_c && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q           <= SB_NONE;
            mem_q          <= SB_NONE;
            wb_q           <= SB_NONE;
            state_q        <= ST_IDLE;
            mc_cnt_q       <= 4'd0;
            stall_cycles_q <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            state_q        <= state_d;
            mc_cnt_q       <= mc_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.stall        = stall_c;
    assign hz.ex_bubble    = bubble_c;
    assign hz.ex_hold      = mc_hold;
    assign hz.fwd_rs1_sel  = fwd1_c;
    assign hz.fwd_rs2_sel  = fwd2_c;
    assign hz.mc_busy      = (state_q == ST_MC_BUSY);
    assign hz.stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_hazard_ctrl
// Brief    : Directed and randomized checks of exec_hazard_ctrl against an
//            instruction-level pipeline model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_exec_hazard_ctrl;

    localparam int MC_LATENCY = 4;
    localparam int CNT_W      = 5;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    exec_hazard_if #(.CNT_W(CNT_W)) hz ();

    exec_hazard_ctrl #(.MC_LATENCY(MC_LATENCY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: which instruction sits in EX and MEM, and how
    // many more cycles a multi-cycle op must keep EX frozen.
    typedef struct {
        bit v;
        bit we;
        bit ld;
        int rd;
    } instr_t;

    instr_t m_ex, m_mem;
    int     m_left;
    bit     m_busy;
    int     m_stalls;
    bit     e_stall, e_bub, e_hold, e_issue;
    int     e_f[2];

    function automatic bit writes(input instr_t e);
        return e.v && e.we && (e.rd != 0);
    endfunction

    task automatic model_reset();
        m_ex     = '{v: 0, we: 0, ld: 0, rd: 0};
        m_mem    = '{v: 0, we: 0, ld: 0, rd: 0};
        m_left   = 0;
        m_busy   = 0;
        m_stalls = 0;
    endtask

    task automatic model_eval();
        int rs[2];
        bit used[2];
        bit lu;
        rs[0] = int'(hz.id_rs1_sel);  used[0] = hz.id_rs1_used;
        rs[1] = int'(hz.id_rs2_sel);  used[1] = hz.id_rs2_used;
        e_hold = (m_left > 0);
        lu = 0;
        for (int i = 0; i < 2; i++) begin
            bit hit_ex, hit_mem;
            hit_ex  = used[i] && writes(m_ex)  && (rs[i] == m_ex.rd);
            hit_mem = used[i] && writes(m_mem) && (rs[i] == m_mem.rd);
            if (hit_ex && m_ex.ld) lu = 1;
            if (hit_ex && !m_ex.ld && !e_hold) e_f[i] = 1;
            else if (hit_mem)                  e_f[i] = 2;
            else                               e_f[i] = 0;
        end
        lu = lu && hz.id_valid;
        if (e_hold) begin
            e_stall = 1; e_bub = 0;
        end else if (hz.branch_flush) begin
            e_stall = 0; e_bub = 1;
        end else begin
            e_stall = lu; e_bub = lu;
        end
        e_issue = hz.id_valid && !e_stall && !hz.branch_flush;
    endtask

    task automatic model_advance();
        if (e_hold) begin
            m_left--;
            m_mem = '{v: 0, we: 0, ld: 0, rd: 0};
        end else begin
            m_mem  = m_ex;
            m_ex   = e_issue ? '{v: 1, we: hz.id_write_enable, ld: hz.id_is_load,
                                 rd: int'(hz.id_rd_sel)}
                             : '{v: 0, we: 0, ld: 0, rd: 0};
            m_busy = e_issue && hz.id_is_mc;
            m_left = m_busy ? MC_LATENCY - 1 : 0;
        end
        if (e_stall && m_stalls < SAT) m_stalls++;
    endtask

    // Compare process: every cycle, after inputs settle and before the edge.
    initial model_reset();
    always begin
        @(negedge clk);
        #3;
        if (!rst_n) model_reset();
        model_eval();
        check("stall",        hz.stall,        e_stall);
        check("ex_bubble",    hz.ex_bubble,    e_bub);
        check("ex_hold",      hz.ex_hold,      e_hold);
        check("fwd_rs1_sel",  hz.fwd_rs1_sel,  e_f[0]);
        check("fwd_rs2_sel",  hz.fwd_rs2_sel,  e_f[1]);
        check("mc_busy",      hz.mc_busy,      m_busy);
        check("stall_cycles", hz.stall_cycles, m_stalls);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_advance();
    end

    task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit we, input bit ld, input bit mc, input bit fl);
        hz.id_valid        = v;
        hz.id_rs1_sel      = 5'(rs1);
        hz.id_rs1_used     = u1;
        hz.id_rs2_sel      = 5'(rs2);
        hz.id_rs2_used     = u2;
        hz.id_rd_sel       = 5'(rd);
        hz.id_write_enable = we;
        hz.id_is_load      = ld;
        hz.id_is_mc        = mc;
        hz.branch_flush    = fl;
    endtask

    task automatic op(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input bit ld, input bit mc, input bit fl);
        @(negedge clk);
        set_in(v, rs1, u1, rs2, u2, rd, we, ld, mc, fl);
        #4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #15;
        check("rst_stall",  hz.stall,        0);
        check("rst_bubble", hz.ex_bubble,    0);
        check("rst_busy",   hz.mc_busy,      0);
        check("rst_cnt",    hz.stall_cycles, 0);
        do_reset();

        // EX producer forwards to the next instruction
        op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        op(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check("fwd_ex", hz.fwd_rs1_sel, 1);
        check("fwd_ex_nostall", hz.stall, 0);
        // MEM producer after a gap
        op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        op(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check("fwd_mem", hz.fwd_rs1_sel, 2);
        // EX wins over MEM
        op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        op(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        check("fwd_prio1", hz.fwd_rs1_sel, 1);
        check("fwd_prio2", hz.fwd_rs2_sel, 1);
        // x0 never hazards
        op(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        op(1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
        check("x0_fwd", hz.fwd_rs1_sel, 0);
        check("x0_stall", hz.stall, 0);

        // Load-use: one bubble then MEM forwarding
        do_reset();
        op(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        op(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
        check("lu_stall", hz.stall, 1);
        check("lu_bubble", hz.ex_bubble, 1);
        op(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
        check("lu_release", hz.stall, 0);
        check("lu_fwd", hz.fwd_rs2_sel, 2);
        check("lu_cnt", hz.stall_cycles, 1);

        // Multi-cycle op with dependent follower
        do_reset();
        op(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
        check("mc_issue_busy", hz.mc_busy, 0);
        for (int k = 0; k < MC_LATENCY - 1; k++) begin
            op(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
            check("mc_stall", hz.stall, 1);
            check("mc_hold", hz.ex_hold, 1);
            check("mc_busy", hz.mc_busy, 1);
        end
        op(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
        check("mc_rel_stall", hz.stall, 0);
        check("mc_rel_busy", hz.mc_busy, 1);
        check("mc_rel_fwd", hz.fwd_rs1_sel, 1);
        check("mc_cnt", hz.stall_cycles, 3);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mc_done", hz.mc_busy, 0);

        // Flush overrides load-use and issues nothing
        do_reset();
        op(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        op(1, 0, 0, 7, 1, 8, 1, 0, 0, 1);
        check("fl_stall", hz.stall, 0);
        check("fl_bubble", hz.ex_bubble, 1);
        op(1, 8, 1, 7, 1, 1, 1, 0, 0, 0);
        check("fl_noissue", hz.fwd_rs1_sel, 0);
        check("fl_ldmem", hz.fwd_rs2_sel, 2);

        // Reset dropped while the counter is 2
        do_reset();
        op(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
        op(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
        op(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
        check("mr_pre_stall", hz.stall, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check("mr_stall", hz.stall, 0);
        check("mr_hold", hz.ex_hold, 0);
        check("mr_busy", hz.mc_busy, 0);
        check("mr_bubble", hz.ex_bubble, 0);
        check("mr_cnt", hz.stall_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
        check("mr_add_stall", hz.stall, 0);
        check("mr_add_fwd", hz.fwd_rs1_sel, 0);

        // Randomized traffic over a small register window to force hazards
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit v, ld;
            @(negedge clk);
            v  = ($urandom_range(3) != 0);
            ld = ($urandom_range(3) == 0);
            set_in(v, $urandom_range(3), v && $urandom_range(1),
                   $urandom_range(3), v && $urandom_range(1),
                   $urandom_range(3), ($urandom_range(4) != 0), ld,
                   !ld && ($urandom_range(9) == 0), ($urandom_range(12) == 0));
        end
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (MC_LATENCY + 1) @(negedge clk);
        #4;
        check("sat_cnt", hz.stall_cycles, SAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
